// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding, dynamic-opcode selector value and parameter limits for the ALU pipe.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_SEL = 3'd6,
        OP_MAC = 3'd7
    } alu_op_e;

    localparam int FUNC_DYNAMIC    = 8;
    localparam int DATA_WIDTH_MIN  = 8;
    localparam int DATA_WIDTH_MAX  = 64;
    localparam int PIPE_STAGES_MIN = 1;
    localparam int PIPE_STAGES_MAX = 4;

    // A fixed configuration ignores the func port entirely.
    function automatic alu_op_e resolve_op(input int cfg, input logic [2:0] dyn);
        if (cfg == FUNC_DYNAMIC) begin
            return alu_op_e'(dyn);
        end
        return alu_op_e'(3'(cfg));
    endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One pipeline register stage: valid bit plus data, loads when empty or when downstream has room.
// Zero-bubble: room_i is the combinational "my content will be taken this edge" signal.
module alu_pipe_stage
    import alu_pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         load_vld_i,
    input  logic [W-1:0] load_dat_i,
    input  logic         room_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;
    logic         adv;

    assign adv = en_i && (!vld_q || room_i);

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (adv) begin
            vld_d = load_vld_i;
            // Data only moves with a real item so bubbles leave the register quiet.
            if (load_vld_i) begin
                dat_d = load_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/alu_pipe_unit.sv
// Pipelined 8-op ALU with accumulator: PIPE_STAGES cycles accept-to-output, one transfer per cycle.
// Backpressure from out_ready ripples back combinationally to in_ready; en low freezes everything.
module alu_pipe_unit
    import alu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_STAGES = 2,
    parameter int ALU_FUNC    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            func,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  zero,
    input  logic                  acc_clr
);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
        $error("alu_pipe_unit: DATA_WIDTH out of range");
    end
    if (PIPE_STAGES < PIPE_STAGES_MIN || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_bad_stages
        $error("alu_pipe_unit: PIPE_STAGES out of range");
    end
    if (ALU_FUNC < 0 || ALU_FUNC > FUNC_DYNAMIC) begin : g_bad_func
        $error("alu_pipe_unit: ALU_FUNC out of range");
    end

    alu_op_e               op;
    logic                  accept;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] acc_base;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  unused_in3;

    logic [PIPE_STAGES-1:0] stg_vld;
    logic [PIPE_STAGES-1:0] room;
    logic [DATA_WIDTH-1:0]  stg_dat [PIPE_STAGES];

    assign unused_in3 = ^data_in3[DATA_WIDTH-1:1];

    assign op = resolve_op(ALU_FUNC, func);

    // room[k]: whatever sits in stage k leaves on this edge (some later slot is free or the sink takes).
    always_comb begin
        room[PIPE_STAGES-1] = out_ready;
        for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
            room[k] = room[k+1] || !stg_vld[k+1];
        end
    end

    assign in_ready = !rst && en && (!stg_vld[0] || room[0]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        prod     = data_in1 * data_in2;
        acc_base = acc_clr ? '0 : acc_q;
        alu_res  = '0;
        case (op)
            OP_ADD:  alu_res = data_in1 + data_in2;
            OP_SUB:  alu_res = data_in1 - data_in2;
            OP_AND:  alu_res = data_in1 & data_in2;
            OP_OR:   alu_res = data_in1 | data_in2;
            OP_XOR:  alu_res = data_in1 ^ data_in2;
            OP_MUL:  alu_res = prod;
            OP_SEL:  alu_res = data_in3[0] ? data_in2 : data_in1;
            OP_MAC:  alu_res = acc_base + prod;
            default: alu_res = '0;
        endcase
    end

    // Clear takes effect before a same-cycle MAC, so the MAC starts from zero.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            if (accept && op == OP_MAC) begin
                acc_d = alu_res;
            end else if (acc_clr) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        logic                  ld_vld;
        logic [DATA_WIDTH-1:0] ld_dat;

        if (k == 0) begin : g_head
            assign ld_vld = accept;
            assign ld_dat = alu_res;
        end else begin : g_body
            assign ld_vld = stg_vld[k-1];
            assign ld_dat = stg_dat[k-1];
        end

        alu_pipe_stage #(
            .W (DATA_WIDTH)
        ) u_stage (
            .clk_i      (clk),
            .rst_i      (rst),
            .en_i       (en),
            .load_vld_i (ld_vld),
            .load_dat_i (ld_dat),
            .room_i     (room[k]),
            .vld_o      (stg_vld[k]),
            .dat_o      (stg_dat[k])
        );
    end

    assign out_valid = stg_vld[PIPE_STAGES-1];
    assign data_out  = stg_dat[PIPE_STAGES-1];
    assign zero      = out_valid && (data_out == '0);

endmodule
